// File: rtl/spi_pkg.sv
// Constants and FSM encoding shared between the SPI receiver and the SPI master.
package spi_pkg;

    localparam int FRAME_BITS = 8;
    localparam int ADDR_W     = 4;
    localparam int DATA_W     = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_FULL  = 2'd2,
        ST_ERR   = 2'd3
    } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser plus history flop; flags level changes seen after the second stage.
module spi_sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rstn,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic s1, s2, hist;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1   <= RESET_VAL;
            s2   <= RESET_VAL;
            hist <= RESET_VAL;
        end else begin
            s1   <= din;
            s2   <= s1;
            hist <= s2;
        end
    end

    assign level = s2;
    assign rise  = s2 & ~hist;
    assign fall  = ~s2 & hist;

endmodule

// File: rtl/spi_rx_regfile.sv
// SPI slave receiver: collects address/data frames and commits them into a 16x4 register file.
//   state | meaning
//   IDLE  | waiting for a csn fall
//   SHIFT | collecting frame bits
//   FULL  | frame complete, commit on csn rise
//   ERR   | overrun seen, discard on csn rise
module spi_rx_regfile
    import spi_pkg::*;
#(
    parameter int FRAME_BITS    = spi_pkg::FRAME_BITS,
    parameter int CLK_RATIO_MIN = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              spi_clk,
    input  logic              spi_csn,
    input  logic              data_bit,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              wr_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              frame_err,
    output logic [7:0]        good_cnt
);

    localparam int CNT_W = $clog2(FRAME_BITS + 1);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [3:0] MIN_GAP = 4'(CLK_RATIO_MIN / 2 - 1);

    logic clk_lvl, clk_rise, clk_fall;
    logic csn_lvl, csn_rise, csn_fall;
    logic data_lvl, data_rise, data_fall;

    spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_clk (
        .clk(clk), .rstn(rstn), .din(spi_clk),
        .level(clk_lvl), .rise(clk_rise), .fall(clk_fall)
    );
    spi_sync_edge #(.RESET_VAL(1'b1)) u_sync_csn (
        .clk(clk), .rstn(rstn), .din(spi_csn),
        .level(csn_lvl), .rise(csn_rise), .fall(csn_fall)
    );
    spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_data (
        .clk(clk), .rstn(rstn), .din(data_bit),
        .level(data_lvl), .rise(data_rise), .fall(data_fall)
    );

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        bit_cnt;
    logic [FRAME_BITS-1:0]   sr;
    logic [DATA_W-1:0]       regs [DEPTH];
    logic                    start, shift, commit, discard;
    logic                    last_bit;
    logic [ADDR_W-1:0]       fr_addr;
    logic [DATA_W-1:0]       fr_data;

    assign last_bit = (bit_cnt == CNT_W'(FRAME_BITS - 1));
    assign fr_addr  = sr[FRAME_BITS-1 -: ADDR_W];
    assign fr_data  = sr[DATA_W-1:0];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // csn is tested first everywhere so a same-cycle spi_clk edge is dropped
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (csn_fall) state_nxt = ST_SHIFT;
            ST_SHIFT: if (csn_rise)                  state_nxt = ST_IDLE;
                      else if (clk_rise && last_bit) state_nxt = ST_FULL;
            ST_FULL:  if (csn_rise)      state_nxt = ST_IDLE;
                      else if (clk_rise) state_nxt = ST_ERR;
            ST_ERR:   if (csn_rise) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        start   = 1'b0;
        shift   = 1'b0;
        commit  = 1'b0;
        discard = 1'b0;
        case (state)
            ST_IDLE:  start = csn_fall;
            ST_SHIFT: begin
                discard = csn_rise;
                shift   = clk_rise && !csn_rise;
            end
            ST_FULL:  commit  = csn_rise;
            ST_ERR:   discard = csn_rise;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bit_cnt <= '0;
            sr      <= '0;
        end else if (start) begin
            bit_cnt <= '0;
            sr      <= '0;
        end else if (shift) begin
            bit_cnt <= bit_cnt + CNT_W'(1);
            sr      <= {sr[FRAME_BITS-2:0], data_lvl};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
            rd_data   <= '0;
            wr_valid  <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            frame_err <= 1'b0;
            good_cnt  <= '0;
        end else begin
            rd_data   <= regs[rd_addr];
            wr_valid  <= commit;
            frame_err <= discard;
            if (commit) begin
                regs[fr_addr] <= fr_data;
                wr_addr       <= fr_addr;
                wr_data       <= fr_data;
                good_cnt      <= good_cnt + 8'd1;
            end
        end
    end

    // Time since the last spi_clk edge, used only to check the input timing assumption
    logic [3:0] phase_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                     phase_cnt <= '0;
        else if (clk_rise || clk_fall) phase_cnt <= '0;
        else if (phase_cnt != 4'hF)    phase_cnt <= phase_cnt + 4'd1;
    end

    a_phase_len: assert property (@(posedge clk) disable iff (!rstn)
        ((clk_rise || clk_fall) && !csn_lvl) |-> (phase_cnt >= MIN_GAP));
    a_clk_idle_low: assert property (@(posedge clk) disable iff (!rstn)
        csn_rise |-> !clk_lvl);
    a_data_stable: assert property (@(posedge clk) disable iff (!rstn)
        clk_rise |-> !(data_rise || data_fall));
    a_excl_pulses: assert property (@(posedge clk) disable iff (!rstn)
        !(wr_valid && frame_err));

endmodule

// File: tb/tb_spi_rx_regfile.sv
// Directed bench for spi_rx_regfile: SPI frames at clk/8 with hand-computed expectations.
module tb_spi_rx_regfile;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       spi_clk = 1'b0;
    logic       spi_csn = 1'b1;
    logic       data_bit = 1'b0;
    logic [3:0] rd_addr = 4'd0;
    logic [3:0] rd_data;
    logic       wr_valid;
    logic [3:0] wr_addr;
    logic [3:0] wr_data;
    logic       frame_err;
    logic [7:0] good_cnt;

    int vec_cnt  = 0;
    int miss_cnt = 0;
    int wv_seen  = 0;
    int fe_seen  = 0;
    int wv_base, fe_base;

    spi_rx_regfile #(.FRAME_BITS(8), .CLK_RATIO_MIN(4)) dut (
        .clk(clk), .rstn(rstn), .spi_clk(spi_clk), .spi_csn(spi_csn),
        .data_bit(data_bit), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_err(frame_err), .good_cnt(good_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rstn) begin
            if (wr_valid)  wv_seen++;
            if (frame_err) fe_seen++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // spi_clk phases of 4 clk periods each; extra pulses beyond 8 repeat the frame bits
    task automatic send_frame(input logic [7:0] bits, input int npulse, input int gap);
        spi_csn = 1'b0;
        wait_clk(4);
        for (int i = 0; i < npulse; i++) begin
            data_bit = bits[7 - (i % 8)];
            wait_clk(4);
            spi_clk = 1'b1;
            wait_clk(4);
            spi_clk = 1'b0;
        end
        wait_clk(4);
        spi_csn = 1'b1;
        wait_clk(gap);
    endtask

    task automatic rd_chk(input logic [3:0] addr, input logic [3:0] exp, input string tag);
        rd_addr = addr;
        wait_clk(1);
        chk(tag, rd_data, exp);
    endtask

    task automatic mark();
        wv_base = wv_seen;
        fe_base = fe_seen;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        wait_clk(3);
        chk("rst_rd_data",   rd_data,   0);
        chk("rst_wr_valid",  wr_valid,  0);
        chk("rst_wr_addr",   wr_addr,   0);
        chk("rst_wr_data",   wr_data,   0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_good_cnt",  good_cnt,  0);
        rstn = 1'b1;
        wait_clk(3);

        // short frame: 5 bits then csn rise
        mark();
        send_frame(8'h5F, 5, 8);
        chk("short_fe",   fe_seen - fe_base, 1);
        chk("short_wv",   wv_seen - wv_base, 0);
        chk("short_good", good_cnt, 0);
        for (int a = 0; a < 16; a++) rd_chk(4'(a), 4'h0, "short_regs");

        // frame 0011_1010 with commit latency check
        mark();
        send_frame(8'h3A, 8, 0);
        wait_clk(2);
        chk("lat_early", wr_valid, 0);
        wait_clk(1);
        chk("lat_commit", wr_valid, 1);
        wait_clk(1);
        chk("lat_pulse_end", wr_valid, 0);
        wait_clk(3);
        chk("f3a_wv",   wv_seen - wv_base, 1);
        chk("f3a_fe",   fe_seen - fe_base, 0);
        chk("f3a_addr", wr_addr, 4'h3);
        chk("f3a_data", wr_data, 4'hA);
        chk("f3a_good", good_cnt, 1);
        rd_chk(4'h3, 4'hA, "f3a_read");

        // overrun: 9 pulses
        mark();
        send_frame(8'h5C, 9, 8);
        chk("ovr_fe",   fe_seen - fe_base, 1);
        chk("ovr_wv",   wv_seen - wv_base, 0);
        chk("ovr_good", good_cnt, 1);
        rd_chk(4'h5, 4'h0, "ovr_no_write");

        // back-to-back frames with a 3-cycle csn gap
        mark();
        send_frame(8'hF5, 8, 3);
        send_frame(8'h0C, 8, 8);
        chk("b2b_wv",   wv_seen - wv_base, 2);
        chk("b2b_fe",   fe_seen - fe_base, 0);
        chk("b2b_good", good_cnt, 3);
        chk("b2b_addr", wr_addr, 4'h0);
        chk("b2b_data", wr_data, 4'hC);
        rd_chk(4'hF, 4'h5, "b2b_regF");
        rd_chk(4'h0, 4'hC, "b2b_reg0");

        // reset after 4 bits of a frame to address 7
        mark();
        spi_csn = 1'b0;
        wait_clk(4);
        for (int i = 0; i < 4; i++) begin
            data_bit = (i != 0);
            wait_clk(4);
            spi_clk = 1'b1;
            wait_clk(4);
            spi_clk = 1'b0;
        end
        rstn = 1'b0;
        spi_csn = 1'b1;
        wait_clk(1);
        chk("mid_rst_good", good_cnt, 0);
        chk("mid_rst_addr", wr_addr, 0);
        chk("mid_rst_data", wr_data, 0);
        chk("mid_rst_rd",   rd_data, 0);
        rstn = 1'b1;
        wait_clk(8);
        chk("mid_rst_fe", fe_seen - fe_base, 0);
        chk("mid_rst_wv", wv_seen - wv_base, 0);
        mark();
        send_frame(8'h79, 8, 8);
        chk("f79_wv",   wv_seen - wv_base, 1);
        chk("f79_fe",   fe_seen - fe_base, 0);
        chk("f79_addr", wr_addr, 4'h7);
        chk("f79_data", wr_data, 4'h9);
        chk("f79_good", good_cnt, 1);
        rd_chk(4'h7, 4'h9, "f79_read");
        rd_chk(4'hF, 4'h0, "rst_cleared_regF");
        rd_chk(4'h0, 4'h0, "rst_cleared_reg0");

        // read/write collision on address 7
        rd_addr = 4'h7;
        send_frame(8'h74, 8, 0);
        n = 0;
        while (!wr_valid && n < 20) begin
            wait_clk(1);
            n++;
        end
        chk("coll_seen", wr_valid, 1);
        chk("coll_old",  rd_data, 4'h9);
        wait_clk(1);
        chk("coll_new",  rd_data, 4'h4);
        chk("coll_good", good_cnt, 2);

        // good_cnt wrap after 256 frames from reset
        rstn = 1'b0;
        wait_clk(2);
        rstn = 1'b1;
        wait_clk(3);
        mark();
        for (int i = 0; i < 255; i++) begin
            logic [7:0] fr;
            fr = 8'(i);
            send_frame({fr[3:0], ~fr[3:0]}, 8, 3);
        end
        wait_clk(5);
        chk("wrap_255", good_cnt, 8'd255);
        send_frame(8'hA5, 8, 8);
        chk("wrap_0",  good_cnt, 8'd0);
        chk("wrap_wv", wv_seen - wv_base, 256);
        chk("wrap_fe", fe_seen - fe_base, 0);
        rd_chk(4'hA, 4'h5, "wrap_last_write");

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
